// File: rtl/vga_img_pkg.sv
// Shared frame-buffer geometry and scroll FSM state encoding for the VGA
// address path.
package vga_img_pkg;

    localparam int IMG_W      = 320;
    localparam int IMG_H      = 240;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W     = 17;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/frame_tick_prescaler.sv
// Free-running scroll-rate prescaler; latches a pending tick at each wrap
// until the next frame boundary consumes it.
module frame_tick_prescaler #(
    parameter int TICK_DIV = 1048576
) (
    input  logic clk_25MHz,
    input  logic rst_1pulse,
    input  logic clear,
    output logic tick_pend,
    output logic wrap
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign wrap = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk_25MHz or posedge rst_1pulse) begin
        if (rst_1pulse) begin
            cnt       <= '0;
            tick_pend <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            // A frame boundary always wins: a wrap in the same cycle is
            // consumed directly by the caller rather than left pending.
            if (clear)
                tick_pend <= 1'b0;
            else if (wrap)
                tick_pend <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_scroll_addr_gen.sv
// Maps 640x480 raster counters to a 2x-upscaled 320x240 BRAM address with
// frame-synchronous vertical scroll; mirroring is built only with VGA_MIRROR_EN.
module vga_scroll_addr_gen #(
    parameter int IMG_W    = vga_img_pkg::IMG_W,
    parameter int IMG_H    = vga_img_pkg::IMG_H,
    parameter int ADDR_W   = vga_img_pkg::ADDR_W,
    parameter int TICK_DIV = 1048576
) (
    input  logic              clk_25MHz,
    input  logic              rst_1pulse,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              valid_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              en,
    input  logic              dir,
    input  logic              hmir,
    input  logic              vmir,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              valid_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    import vga_img_pkg::*;

    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_UP   = UP;
    localparam logic [1:0] ST_DOWN = DOWN;

    logic [1:0] state;
    logic [1:0] next_state;
    logic [7:0] offset;
    logic       fb;
    logic       tick_pend;
    logic       wrap;
    logic       step_req;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] x_m;
    logic [9:0] y_m;
    logic [9:0] y_s;
    logic [9:0] y_w;
    logic [ADDR_W-1:0] addr_next;
    logic [1:0] valid_d;
    logic [1:0] hsync_d;
    logic [1:0] vsync_d;
    logic       unused_bits;

    assign fb       = (v_cnt == 10'(2 * IMG_H)) && (h_cnt == 10'd0);
    assign step_req = tick_pend | wrap;

    frame_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_25MHz  (clk_25MHz),
        .rst_1pulse (rst_1pulse),
        .clear      (fb),
        .tick_pend  (tick_pend),
        .wrap       (wrap)
    );

    always_comb begin
        next_state = state;
        if (fb) begin
            if (!en)
                next_state = ST_HOLD;
            else if (dir)
                next_state = ST_UP;
            else
                next_state = ST_DOWN;
        end
    end

    // The step at a boundary follows the freshly sampled direction, so a
    // direction change and its first step land on the same frame.
    always_ff @(posedge clk_25MHz or posedge rst_1pulse) begin
        if (rst_1pulse) begin
            state  <= ST_HOLD;
            offset <= 8'd0;
        end else begin
            state <= next_state;
            if (fb && step_req) begin
                case (next_state)
                    ST_UP:   offset <= (offset == 8'(IMG_H - 1)) ? 8'd0 : offset + 8'd1;
                    ST_DOWN: offset <= (offset == 8'd0) ? 8'(IMG_H - 1) : offset - 8'd1;
                    default: offset <= offset;
                endcase
            end
        end
    end

    assign x = {1'b0, h_cnt[9:1]};
    assign y = {1'b0, v_cnt[9:1]};

`ifdef VGA_MIRROR_EN
    assign x_m = hmir ? 10'(IMG_W - 1) - x : x;
    assign y_m = vmir ? 10'(IMG_H - 1) - y : y;
`else
    assign x_m = x;
    assign y_m = y;
`endif

    // Single conditional subtract suffices: both terms are below IMG_H on
    // active lines.
    assign y_s       = y_m + {2'b00, offset};
    assign y_w       = (y_s >= 10'(IMG_H)) ? y_s - 10'(IMG_H) : y_s;
    assign addr_next = (ADDR_W'(y_w) << 8) + (ADDR_W'(y_w) << 6) + ADDR_W'(x_m);

    assign unused_bits = ^{h_cnt[0], v_cnt[0], hmir, vmir};

    always_ff @(posedge clk_25MHz or posedge rst_1pulse) begin
        if (rst_1pulse) begin
            pixel_addr <= '0;
            valid_d    <= 2'b00;
            hsync_d    <= 2'b11;
            vsync_d    <= 2'b11;
        end else begin
            pixel_addr <= valid_in ? addr_next : '0;
            valid_d    <= {valid_d[0], valid_in};
            hsync_d    <= {hsync_d[0], hsync_in};
            vsync_d    <= {vsync_d[0], vsync_in};
        end
    end

    assign valid_out = valid_d[1];
    assign hsync_out = hsync_d[1];
    assign vsync_out = vsync_d[1];

endmodule
